nibble_bus_collector: RTL and testbench

Receiving end of the gated 4-bit operand bus in the ALU datapath. Transmitting stages drive a nibble qualified by a select line, so the bus reads 0 whenever the select is low. This block samples qualified nibbles least-significant first and assembles them into a NIBBLES×4-bit word. It presents the word to the downstream ALU register stage with a valid/ready handshake and reports overrun and bus-protocol errors.

---
 rtl/alu_bus_pkg.sv | 18 +
 rtl/nibble_shadow_reg.sv | 34 +++
 rtl/nibble_bus_collector.sv | 130 +++++++++++++
 tb/tb_nibble_bus_collector.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bus_pkg.sv
// Shared definitions for the gated nibble operand bus: nibble width, the
// collector FSM encoding and the bit positions of the sticky error flags.
package alu_bus_pkg;

  localparam int NIB_W = 4;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  localparam int ERR_OVERRUN = 0;
  localparam int ERR_BUS     = 1;
  localparam int ERR_N       = 2;

endpackage

// File: rtl/nibble_shadow_reg.sv
// Shadow register that accumulates nibbles of the word under construction.
// o_next is the register contents with this cycle's write already applied.
module nibble_shadow_reg
  import alu_bus_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_wr_en,
  input  logic [CNT_W-1:0]           i_wr_idx,
  input  logic [NIB_W-1:0]           i_wr_nib,
  input  logic                       i_clr,
  output logic [NIB_W*NIBBLES-1:0]   o_next
);

  logic [NIB_W*NIBBLES-1:0] r_data;
  logic [NIBBLES-1:0]       w_we;

  for (genvar k = 0; k < NIBBLES; k++) begin : g_nib
    assign w_we[k] = i_wr_en && (i_wr_idx == CNT_W'(k));
    assign o_next[k*NIB_W +: NIB_W] = w_we[k] ? i_wr_nib : r_data[k*NIB_W +: NIB_W];
  end

  // Clearing after each completed word keeps unfilled upper nibbles zero.
  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_data <= '0;
    end else begin
      r_data <= o_next;
    end
  end

endmodule

// File: rtl/nibble_bus_collector.sv
// Assembles qualified nibbles (LSB first) from the gated operand bus into a
// word and offers it downstream; reports dropped nibbles and bus glitches.
//
// Handshake: word_out is offered while word_valid=1 and held stable; the
// transfer happens on the rising edge where word_valid=1 and word_ready=1.
// word_ready is ignored while word_valid=0.
module nibble_bus_collector
  import alu_bus_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NIB_W-1:0]           bus_data,
  input  logic                       bus_sel,
  input  logic                       bus_last,
  output logic [NIB_W*NIBBLES-1:0]   word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [CNT_W-1:0]           nib_count,
  output logic                       overrun,
  output logic                       bus_err,
  input  logic                       err_clr,
  output state_e                     dbg_state
);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [CNT_W-1:0]         r_nib_count;
  logic [CNT_W-1:0]         w_count_nxt;
  logic [CNT_W-1:0]         w_idx;
  logic [NIB_W*NIBBLES-1:0] r_word_out;
  logic [NIB_W*NIBBLES-1:0] w_shadow_next;
  logic [ERR_N-1:0]         r_err;
  logic [ERR_N-1:0]         w_err_set;
  logic                     w_accept;
  logic                     w_final;
  logic                     w_load;

  nibble_shadow_reg #(
    .NIBBLES (NIBBLES)
  ) u_shadow (
    .clock    (clock),
    .reset    (reset),
    .i_wr_en  (w_accept),
    .i_wr_idx (w_idx),
    .i_wr_nib (bus_data),
    .i_clr    (w_load),
    .o_next   (w_shadow_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_nib_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_nib_count <= w_count_nxt;
    end
  end

  // In HOLD a nibble is only taken as a handoff; it always starts a new word.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_nib_count;
    w_idx       = r_nib_count;
    w_accept    = 1'b0;
    w_final     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE, ST_COLLECT: begin
        w_accept = bus_sel;
      end
      ST_HOLD: begin
        w_idx = '0;
        if (word_ready) begin
          w_accept    = bus_sel;
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    endcase
    w_final = bus_last || (w_idx == CNT_W'(NIBBLES - 1));
    if (w_accept) begin
      if (w_final) begin
        w_state_nxt = ST_HOLD;
        w_count_nxt = '0;
        w_load      = 1'b1;
      end else begin
        w_state_nxt = ST_COLLECT;
        w_count_nxt = w_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_word_out <= '0;
    end else if (w_load) begin
      r_word_out <= w_shadow_next;
    end
  end

  always_comb begin
    w_err_set              = '0;
    w_err_set[ERR_OVERRUN] = bus_sel && (r_state == ST_HOLD) && !word_ready;
    w_err_set[ERR_BUS]     = !bus_sel && (bus_data != '0);
  end

  // A new error in the same cycle as err_clr leaves the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      r_err <= (err_clr ? '0 : r_err) | w_err_set;
    end
  end

  assign word_out   = r_word_out;
  assign word_valid = (r_state == ST_HOLD);
  assign nib_count  = r_nib_count;
  assign overrun    = r_err[ERR_OVERRUN];
  assign bus_err    = r_err[ERR_BUS];
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_nibble_bus_collector.sv
// Bench for nibble_bus_collector: directed vector table, hand-written reset
// sequence, and random traffic checked against a queue-based reference model.
module tb_nibble_bus_collector;
  import alu_bus_pkg::*;

  localparam int NIBBLES = 4;
  localparam int W       = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    bus_data = '0;
  logic          bus_sel = 1'b0;
  logic          bus_last = 1'b0;
  logic [W-1:0]  word_out;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic [2:0]    nib_count;
  logic          overrun;
  logic          bus_err;
  logic          err_clr = 1'b0;
  state_e        dbg_state;

  nibble_bus_collector #(.NIBBLES(NIBBLES)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus_data   (bus_data),
    .bus_sel    (bus_sel),
    .bus_last   (bus_last),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .nib_count  (nib_count),
    .overrun    (overrun),
    .bus_err    (bus_err),
    .err_clr    (err_clr),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic ev, input logic [W-1:0] ew,
                            input logic [2:0] ec, input logic eo, input logic ee);
    chk({nm, ".valid"}, 32'(word_valid), 32'(ev));
    chk({nm, ".word"},  32'(word_out),   32'(ew));
    chk({nm, ".count"}, 32'(nib_count),  32'(ec));
    chk({nm, ".ovr"},   32'(overrun),    32'(eo));
    chk({nm, ".err"},   32'(bus_err),    32'(ee));
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input logic s, input logic [3:0] d, input logic l,
                        input logic r, input logic c);
    bus_sel = s; bus_data = d; bus_last = l; word_ready = r; err_clr = c;
  endtask

  task automatic step(input logic s, input logic [3:0] d, input logic l,
                      input logic r, input logic c);
    set_in(s, d, l, r, c);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         sel;
    logic [3:0]   data;
    logic         last;
    logic         ready;
    logic         clr;
    logic         e_valid;
    logic [W-1:0] e_word;
    logic [2:0]   e_cnt;
    logic         e_ovr;
    logic         e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic [3:0] d, input logic l, input logic r,
                     input logic c, input logic ev, input logic [W-1:0] ew,
                     input logic [2:0] ec, input logic eo, input logic ee);
    vec_t v;
    v.sel = s; v.data = d; v.last = l; v.ready = r; v.clr = c;
    v.e_valid = ev; v.e_word = ew; v.e_cnt = ec; v.e_ovr = eo; v.e_err = ee;
    vecs.push_back(v);
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [3:0]   m_part[$];
  bit           m_hv;
  logic [W-1:0] m_word;
  bit           m_ovr;
  bit           m_err;
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    m_part.delete();
    m_hv = 0; m_word = '0; m_ovr = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic s, input logic [3:0] d, input logic l,
                            input logic r, input logic c);
    bit hv_before = m_hv;
    bit ovr_set = 0;
    bit err_set = 0;
    int word_val;
    if (hv_before && r) begin
      exp_q.push_back(m_word);
      m_hv = 0;
    end
    if (s) begin
      if (hv_before && !r) begin
        ovr_set = 1;
      end else begin
        m_part.push_back(d);
        if (l || m_part.size() == NIBBLES) begin
          word_val = 0;
          for (int k = 0; k < m_part.size(); k++) word_val += int'(m_part[k]) * (16 ** k);
          m_word = W'(word_val);
          m_hv = 1;
          m_part.delete();
        end
      end
    end else if (d != 4'h0) begin
      err_set = 1;
    end
    m_ovr = (c ? 1'b0 : m_ovr) | ovr_set;
    m_err = (c ? 1'b0 : m_err) | err_set;
  endtask

  // ---------------- test ----------------
  logic         rs, rl, rr, rc;
  logic [3:0]   rd;
  logic [W-1:0] got;

  initial begin
    // full word
    add(1,4'hD,0,1,0, 0,16'h0000,1,0,0);
    add(1,4'hA,0,1,0, 0,16'h0000,2,0,0);
    add(1,4'h3,0,1,0, 0,16'h0000,3,0,0);
    add(1,4'h7,0,1,0, 1,16'h73AD,0,0,0);
    add(0,4'h0,0,1,0, 0,16'h73AD,0,0,0);
    // short word
    add(1,4'h5,0,1,0, 0,16'h73AD,1,0,0);
    add(1,4'hC,1,1,0, 1,16'h00C5,0,0,0);
    add(0,4'h0,0,1,0, 0,16'h00C5,0,0,0);
    // overrun while holding
    add(1,4'h4,0,0,0, 0,16'h00C5,1,0,0);
    add(1,4'h3,0,0,0, 0,16'h00C5,2,0,0);
    add(1,4'h2,0,0,0, 0,16'h00C5,3,0,0);
    add(1,4'h1,0,0,0, 1,16'h1234,0,0,0);
    add(1,4'hF,0,0,0, 1,16'h1234,0,1,0);
    add(0,4'h0,0,0,0, 1,16'h1234,0,1,0);
    add(0,4'h0,0,1,0, 0,16'h1234,0,1,0);
    add(0,4'h0,0,0,1, 0,16'h1234,0,0,0);
    // bus glitch and clear
    add(0,4'h2,0,0,0, 0,16'h1234,0,0,1);
    add(0,4'h0,0,0,1, 0,16'h1234,0,0,0);
    // back-to-back handoff
    add(1,4'h1,0,1,0, 0,16'h1234,1,0,0);
    add(1,4'h2,0,1,0, 0,16'h1234,2,0,0);
    add(1,4'h3,0,1,0, 0,16'h1234,3,0,0);
    add(1,4'h4,0,1,0, 1,16'h4321,0,0,0);
    add(1,4'h5,0,1,0, 0,16'h4321,1,0,0);
    add(1,4'h6,0,1,0, 0,16'h4321,2,0,0);
    add(1,4'h7,0,1,0, 0,16'h4321,3,0,0);
    add(1,4'h8,0,1,0, 1,16'h8765,0,0,0);
    add(0,4'h0,0,1,0, 0,16'h8765,0,0,0);
    // set wins over clear
    add(0,4'h1,0,0,1, 0,16'h8765,0,0,1);
    add(0,4'h0,0,0,1, 0,16'h8765,0,0,0);
    // glitch mid-word leaves count alone; handoff of a one-nibble word
    add(1,4'h9,0,1,0, 0,16'h8765,1,0,0);
    add(0,4'h2,0,1,0, 0,16'h8765,1,0,1);
    add(0,4'h0,0,1,1, 0,16'h8765,1,0,0);
    add(1,4'hA,1,1,0, 1,16'h00A9,0,0,0);
    add(1,4'hB,1,1,0, 1,16'h000B,0,0,0);
    add(0,4'h0,0,1,0, 0,16'h000B,0,0,0);

    do_reset();
    check_outs("reset", 0, 16'h0000, 0, 0, 0);
    chk("reset.state", 32'(dbg_state), 32'(ST_IDLE));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sel, vecs[i].data, vecs[i].last, vecs[i].ready, vecs[i].clr);
      check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_word,
                 vecs[i].e_cnt, vecs[i].e_ovr, vecs[i].e_err);
    end

    // reset mid-word discards the partial word
    step(1, 4'hE, 0, 1, 0);
    step(1, 4'hE, 0, 1, 0);
    chk("midrst.pre_count", 32'(nib_count), 32'd2);
    reset = 1'b1;
    step(0, 4'h0, 0, 1, 0);
    reset = 1'b0;
    check_outs("midrst", 0, 16'h0000, 0, 0, 0);
    step(1, 4'h9, 0, 1, 0);
    step(1, 4'h8, 0, 1, 0);
    step(1, 4'h7, 0, 1, 0);
    check_outs("midrst.partial", 0, 16'h0000, 3, 0, 0);
    step(1, 4'h6, 0, 1, 0);
    check_outs("midrst.word", 1, 16'h6789, 0, 0, 0);

    // random traffic against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 9) < 6);
      rd = rs ? 4'($urandom_range(0, 15))
              : (($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
      rl = ($urandom_range(0, 4) == 0);
      rr = ($urandom_range(0, 9) < 6);
      rc = ($urandom_range(0, 19) == 0);
      set_in(rs, rd, rl, rr, rc);
      model_step(rs, rd, rl, rr, rc);
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rnd%0d.xfer: got word %0h expected no transfer", i, word_out);
        end else begin
          got = exp_q.pop_front();
          chk($sformatf("rnd%0d.xfer", i), 32'(word_out), 32'(got));
        end
      end
      @(posedge clock);
      #1;
      check_outs($sformatf("rnd%0d", i), m_hv, m_word, 3'(m_part.size()), m_ovr, m_err);
    end
    chk("rnd.pending", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
